edp_ar_regs: RTL

AR, ARX and MQ register bank of the EDP datapath, sitting directly downstream of the CTL board. Consumes CTL's per-field load/clear strobes and mux selects, and captures one of the datapath sources (AD, ADX, SH, cache data, EBUS) into the AR/ARX/MQ words each clock. Its AR output feeds back into CTL for the XCRY/carry logic.

---
 rtl/edp_pkg.sv | 56 +++++
 rtl/edp_word_mux.sv | 33 +++
 rtl/edp_ar_regs.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/edp_pkg.sv
// Shared types and encodings for the EDP datapath register blocks.
// Words use PDP-10 numbering: bit 0 is the MSB, bit 35 the LSB.
package edp_pkg;

  typedef logic [0:35] word36_t;

  localparam int unsigned WORD_W = 36;

  // Field boundaries (last bit of each left-half field)
  localparam int unsigned AR_F0_LAST = 8;   // AR00to08 load field
  localparam int unsigned AR_C0_LAST = 11;  // AR00to11 clear field
  localparam int unsigned AR_L_LAST  = 17;  // end of left half

  // AR left/right source select
  localparam logic [2:0] AR_SEL_AR      = 3'd0;
  localparam logic [2:0] AR_SEL_CACHE   = 3'd1;
  localparam logic [2:0] AR_SEL_AD      = 3'd2;
  localparam logic [2:0] AR_SEL_EBUS    = 3'd3;
  localparam logic [2:0] AR_SEL_SH      = 3'd4;
  localparam logic [2:0] AR_SEL_AD_X2   = 3'd5;
  localparam logic [2:0] AR_SEL_ADX     = 3'd6;
  localparam logic [2:0] AR_SEL_AD_DIV4 = 3'd7;

  // ARX left/right source select
  localparam logic [2:0] ARX_SEL_ARX      = 3'd0;
  localparam logic [2:0] ARX_SEL_CACHE    = 3'd1;
  localparam logic [2:0] ARX_SEL_AD       = 3'd2;
  localparam logic [2:0] ARX_SEL_MQ       = 3'd3;
  localparam logic [2:0] ARX_SEL_SH       = 3'd4;
  localparam logic [2:0] ARX_SEL_ADX_X2   = 3'd5;
  localparam logic [2:0] ARX_SEL_ADX      = 3'd6;
  localparam logic [2:0] ARX_SEL_ADX_DIV4 = 3'd7;

  // MQ next-value select
  localparam logic [1:0] MQ_SEL_HOLD  = 2'd0;
  localparam logic [1:0] MQ_SEL_MQM   = 2'd1;
  localparam logic [1:0] MQ_SEL_X2    = 2'd2;
  localparam logic [1:0] MQ_SEL_HOLD3 = 2'd3;

  // MQM mux select
  localparam logic [1:0] MQM_SEL_MQ_DIV4 = 2'd0;
  localparam logic [1:0] MQM_SEL_SH      = 2'd1;
  localparam logic [1:0] MQM_SEL_AD_DIV4 = 2'd2;
  localparam logic [1:0] MQM_SEL_ZERO    = 2'd3;

  // Build a mask with ones on bits [first:last] (PDP-10 numbering)
  function automatic word36_t field_mask(input int unsigned first, input int unsigned last);
    word36_t m;
    m = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      if (i >= first && i <= last) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/edp_word_mux.sv
// 8:1 mux of 36-bit words; shared by the AR and ARX source paths.
module edp_word_mux
  import edp_pkg::*;
(
  input  logic [2:0] sel,
  input  word36_t    in0,
  input  word36_t    in1,
  input  word36_t    in2,
  input  word36_t    in3,
  input  word36_t    in4,
  input  word36_t    in5,
  input  word36_t    in6,
  input  word36_t    in7,
  output word36_t    y
);

  // Pure select; no state
  always_comb begin
    y = in0;
    case (sel)
      3'd0: y = in0;
      3'd1: y = in1;
      3'd2: y = in2;
      3'd3: y = in3;
      3'd4: y = in4;
      3'd5: y = in5;
      3'd6: y = in6;
      3'd7: y = in7;
      default: y = in0;
    endcase
  end

endmodule

// File: rtl/edp_ar_regs.sv
// AR / ARX / MQ register bank. Captures datapath sources under CTL
// field strobes; all outputs are direct flop outputs.
module edp_ar_regs
  import edp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       CTL_AR00to08load,
  input  logic       CTL_AR09to17load,
  input  logic       CTL_ARRload,
  input  logic       CTL_AR00to11clr,
  input  logic       CTL_AR12to17clr,
  input  logic       CTL_ARRclr,
  input  logic [2:0] CTL_ARL_SEL,
  input  logic [2:0] CTL_ARR_SEL,
  input  logic [2:0] CTL_ARXL_SEL,
  input  logic [2:0] CTL_ARXR_SEL,
  input  logic       CTL_ARX_LOAD,
  input  logic [1:0] CTL_MQ_SEL,
  input  logic [1:0] CTL_MQM_SEL,
  input  logic       CTL_MQM_EN,
  input  word36_t    EDP_AD,
  input  word36_t    EDP_ADX,
  input  word36_t    EDP_SH,
  input  word36_t    CACHE_DATA,
  input  word36_t    EBUS_D,
  output word36_t    EDP_AR,
  output word36_t    EDP_ARX,
  output word36_t    EDP_MQ,
  output logic       EDP_AR_ZERO
);

  localparam word36_t MASK_LD0 = field_mask(0, AR_F0_LAST);
  localparam word36_t MASK_LD1 = field_mask(AR_F0_LAST + 1, AR_L_LAST);
  localparam word36_t MASK_CL0 = field_mask(0, AR_C0_LAST);
  localparam word36_t MASK_CL1 = field_mask(AR_C0_LAST + 1, AR_L_LAST);
  localparam word36_t MASK_R   = field_mask(AR_L_LAST + 1, WORD_W - 1);

  word36_t ar_q, arx_q, mq_q;
  logic    ar_zero_q;

  word36_t ad_x2, ad_div4, adx_x2, adx_div4, mq_div4, mq_x2;
  word36_t arl_src, arr_src, arxl_src, arxr_src;
  word36_t ar_src, arx_src;
  word36_t ld_mask, clr_mask;
  word36_t ar_next, arx_next, mq_next;
  word36_t mqm_raw, mqm;

  // Shifted forms over the full word; self references use pre-edge MQ
  always_comb begin
    ad_x2    = {EDP_AD[1:35], EDP_ADX[0]};
    ad_div4  = {EDP_AD[0], EDP_AD[0], EDP_AD[0:33]};
    adx_x2   = {EDP_ADX[1:35], mq_q[0]};
    adx_div4 = {EDP_AD[34:35], EDP_ADX[0:33]};
    mq_div4  = {EDP_ADX[34:35], mq_q[0:33]};
    mq_x2    = {mq_q[1:35], 1'b0};
  end

  edp_word_mux u_arl_mux (
    .sel (CTL_ARL_SEL),
    .in0 (ar_q),    .in1 (CACHE_DATA), .in2 (EDP_AD),  .in3 (EBUS_D),
    .in4 (EDP_SH),  .in5 (ad_x2),      .in6 (EDP_ADX), .in7 (ad_div4),
    .y   (arl_src)
  );

  edp_word_mux u_arr_mux (
    .sel (CTL_ARR_SEL),
    .in0 (ar_q),    .in1 (CACHE_DATA), .in2 (EDP_AD),  .in3 (EBUS_D),
    .in4 (EDP_SH),  .in5 (ad_x2),      .in6 (EDP_ADX), .in7 (ad_div4),
    .y   (arr_src)
  );

  edp_word_mux u_arxl_mux (
    .sel (CTL_ARXL_SEL),
    .in0 (arx_q),   .in1 (CACHE_DATA), .in2 (EDP_AD),  .in3 (mq_q),
    .in4 (EDP_SH),  .in5 (adx_x2),     .in6 (EDP_ADX), .in7 (adx_div4),
    .y   (arxl_src)
  );

  edp_word_mux u_arxr_mux (
    .sel (CTL_ARXR_SEL),
    .in0 (arx_q),   .in1 (CACHE_DATA), .in2 (EDP_AD),  .in3 (mq_q),
    .in4 (EDP_SH),  .in5 (adx_x2),     .in6 (EDP_ADX), .in7 (adx_div4),
    .y   (arxr_src)
  );

  // AR next value: clear beats load per bit, so bits 9-11 clear even while loading
  always_comb begin
    ar_src   = {arl_src[0:17], arr_src[18:35]};
    ld_mask  = ({WORD_W{CTL_AR00to08load}} & MASK_LD0)
             | ({WORD_W{CTL_AR09to17load}} & MASK_LD1)
             | ({WORD_W{CTL_ARRload}}      & MASK_R);
    clr_mask = ({WORD_W{CTL_AR00to11clr}}  & MASK_CL0)
             | ({WORD_W{CTL_AR12to17clr}}  & MASK_CL1)
             | ({WORD_W{CTL_ARRclr}}       & MASK_R);
    ar_next  = ~clr_mask & ((ld_mask & ar_src) | (~ld_mask & ar_q));
  end

  // ARX next value: whole-word load or hold
  always_comb begin
    arx_src  = {arxl_src[0:17], arxr_src[18:35]};
    arx_next = CTL_ARX_LOAD ? arx_src : arx_q;
  end

  // MQM mux gated by its enable, then MQ next-value select
  always_comb begin
    mqm_raw = '0;
    case (CTL_MQM_SEL)
      MQM_SEL_MQ_DIV4: mqm_raw = mq_div4;
      MQM_SEL_SH:      mqm_raw = EDP_SH;
      MQM_SEL_AD_DIV4: mqm_raw = ad_div4;
      MQM_SEL_ZERO:    mqm_raw = '0;
      default:         mqm_raw = '0;
    endcase
    mqm = mqm_raw & {WORD_W{CTL_MQM_EN}};

    mq_next = mq_q;
    case (CTL_MQ_SEL)
      MQ_SEL_HOLD:  mq_next = mq_q;
      MQ_SEL_MQM:   mq_next = mqm;
      MQ_SEL_X2:    mq_next = mq_x2;
      MQ_SEL_HOLD3: mq_next = mq_q;
      default:      mq_next = mq_q;
    endcase
  end

  // Register bank; zero flag tracks the AR value loaded on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_q      <= '0;
      arx_q     <= '0;
      mq_q      <= '0;
      ar_zero_q <= 1'b1;
    end else begin
      ar_q      <= ar_next;
      arx_q     <= arx_next;
      mq_q      <= mq_next;
      ar_zero_q <= (ar_next == '0);
    end
  end

  assign EDP_AR      = ar_q;
  assign EDP_ARX     = arx_q;
  assign EDP_MQ      = mq_q;
  assign EDP_AR_ZERO = ar_zero_q;

endmodule
